// File: rtl/module_alu_multicycle.sv
// Registered ALU with a start/done handshake. Single-cycle logic/arith ops, plus iterative
// shift-add MUL and restoring unsigned DIV/REM that take WIDTH steps.
module module_alu_multicycle #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             div0
);
  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd = 4'd0,  OpSub = 4'd1,  OpAnd = 4'd2,  OpOr  = 4'd3;
  localparam logic [3:0] OpXor = 4'd4,  OpNot = 4'd5,  OpSll = 4'd6,  OpSrl = 4'd7;
  localparam logic [3:0] OpSra = 4'd8,  OpSlt = 4'd9,  OpMul = 4'd10, OpDiv = 4'd11;
  localparam logic [3:0] OpRem = 4'd12;

  typedef enum logic [1:0] {StIdle, StIter, StExec, StDone} state_t;

  state_t           r_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH:0]   r_acc;   // MUL partial product / DIV partial remainder
  logic [WIDTH-1:0] r_x;     // MUL multiplier (shifts right) / DIV dividend -> quotient
  logic [WIDTH-1:0] r_y;     // MUL multiplicand (shifts left)
  logic [SHW-1:0]   r_cnt;

  logic [WIDTH:0]   w_sum, w_dif, w_div_sh, w_div_try;
  logic [SHW-1:0]   w_sh_amt;
  logic [WIDTH-1:0] w_res;
  logic             w_c, w_v, w_div0, w_iter_op;

  assign w_iter_op = (alu_op == OpMul) || (alu_op == OpDiv) || (alu_op == OpRem);

  always_comb begin
    w_sum     = {1'b0, r_a} + {1'b0, r_b};
    w_dif     = {1'b0, r_a} + {1'b0, ~r_b} + {{WIDTH{1'b0}}, 1'b1};
    w_sh_amt  = r_b[SHW-1:0];
    w_div_sh  = {r_acc[WIDTH-1:0], r_x[WIDTH-1]};
    w_div_try = w_div_sh - {1'b0, r_b};
    w_res     = '0;
    w_c       = 1'b0;
    w_v       = 1'b0;
    w_div0    = 1'b0;
    case (r_op)
      OpAdd: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OpSub: begin
        w_res = w_dif[WIDTH-1:0];
        w_c   = ~w_dif[WIDTH];  // no carry out of a + ~b + 1 means a borrow
        w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_dif[WIDTH-1] != r_a[WIDTH-1]);
      end
      OpAnd: w_res = r_a & r_b;
      OpOr:  w_res = r_a | r_b;
      OpXor: w_res = r_a ^ r_b;
      OpNot: w_res = ~r_a;
      OpSll: w_res = r_a << w_sh_amt;
      OpSrl: w_res = r_a >> w_sh_amt;
      OpSra: w_res = $unsigned($signed(r_a) >>> w_sh_amt);
      OpSlt: w_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      OpMul: w_res = r_acc[WIDTH-1:0];
      OpDiv: begin
        w_res  = r_x;
        w_div0 = (r_b == '0);
      end
      OpRem: begin
        w_res  = r_acc[WIDTH-1:0];
        w_div0 = (r_b == '0);
      end
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_cnt      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      alu_result <= '0;
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
      flag_c     <= 1'b0;
      flag_v     <= 1'b0;
      div0       <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            r_op    <= alu_op;
            r_a     <= alu_in1;
            r_b     <= alu_in2;
            r_acc   <= '0;
            r_x     <= alu_in1;
            r_y     <= alu_in2;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= w_iter_op ? StIter : StExec;
          end
        end
        StIter: begin
          if (r_op == OpMul) begin
            if (r_x[0]) r_acc <= r_acc + {1'b0, r_y};
            r_x <= r_x >> 1;
            r_y <= r_y << 1;
          end else if (!w_div_try[WIDTH]) begin
            r_acc <= w_div_try;
            r_x   <= {r_x[WIDTH-2:0], 1'b1};
          end else begin
            r_acc <= w_div_sh;
            r_x   <= {r_x[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == SHW'(WIDTH - 1)) r_state <= StExec;
        end
        StExec: begin
          alu_result <= w_res;
          flag_z     <= (w_res == '0);
          flag_n     <= w_res[WIDTH-1];
          flag_c     <= w_c;
          flag_v     <= w_v;
          div0       <= w_div0;
          done       <= 1'b1;
          r_state    <= StDone;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_module_alu_multicycle.sv
// Bench for module_alu_multicycle: directed cases plus random ops against an arithmetic model.
module tb_module_alu_multicycle;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  alu_op = '0;
  logic [15:0] alu_in1 = '0, alu_in2 = '0;
  logic        busy, done, flag_z, flag_n, flag_c, flag_v, div0;
  logic [15:0] alu_result;

  int n_vec = 0;
  int n_err = 0;

  module_alu_multicycle #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .alu_in1(alu_in1),
    .alu_in2(alu_in2), .busy(busy), .done(done), .alu_result(alu_result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {div0, v, c, n, z, result[15:0]}
  function automatic logic [20:0] model(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    int unsigned ua, ub, r, sh;
    int sa, sb, s;
    logic c, v, d0;
    logic [15:0] res;
    ua = a; ub = b; sa = int'($signed(a)); sb = int'($signed(b));
    sh = ub % 16;
    c = 0; v = 0; d0 = 0; r = 0;
    case (op)
      4'd0: begin r = ua + ub; c = (r > 65535); s = sa + sb; v = (s > 32767) || (s < -32768); end
      4'd1: begin r = ua - ub; c = (ua < ub); s = sa - sb; v = (s > 32767) || (s < -32768); end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: r = ~ua;
      4'd6: r = ua << sh;
      4'd7: r = ua >> sh;
      4'd8: r = int'(sa >>> sh);
      4'd9: r = (sa < sb) ? 1 : 0;
      4'd10: r = ua * ub;
      4'd11: begin d0 = (ub == 0); r = d0 ? 65535 : ua / ub; end
      4'd12: begin d0 = (ub == 0); r = d0 ? ua : ua % ub; end
      default: r = 0;
    endcase
    res = r[15:0];
    return {d0, v, c, res[15], (res == 16'h0), res};
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input bit poke);
    logic [20:0] exp;
    int cyc;
    int lat;
    exp = model(op, a, b);
    lat = (op >= 4'd10 && op <= 4'd12) ? 17 : 1;
    @(negedge clk);
    chk({tag, " busy_idle"}, busy, 0);
    start = 1; alu_op = op; alu_in1 = a; alu_in2 = b;
    @(posedge clk); #1;
    start = 0; alu_op = 4'($urandom); alu_in1 = 16'($urandom); alu_in2 = 16'($urandom);
    chk({tag, " busy_rise"}, {busy, done}, 2'b10);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      start = (poke && cyc == 4);
      @(posedge clk); #1;
      cyc++;
    end
    start = 0;
    chk({tag, " latency"}, cyc, lat);
    chk({tag, " busy_in_done"}, busy, 1);
    chk({tag, " result"}, alu_result, exp[15:0]);
    chk({tag, " flags_dvcnz"}, {div0, flag_v, flag_c, flag_n, flag_z}, exp[20:16]);
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, {busy, done}, 2'b00);
    chk({tag, " held"}, alu_result, exp[15:0]);
  endtask

  initial begin
    int seen;
    #12;
    chk("reset_outs", {busy, done, alu_result, flag_z, flag_n, flag_c, flag_v, div0}, 0);
    @(negedge clk); rst = 0;

    run_op("add_ovf",  4'd0,  16'h7FFF, 16'h0001, 0);
    run_op("sub_brw",  4'd1,  16'h0003, 16'h0005, 0);
    run_op("add_wrap", 4'd0,  16'hFFFF, 16'h0001, 0);
    run_op("mul",      4'd10, 16'h0123, 16'h0010, 0);
    run_op("div",      4'd11, 16'd100,  16'd7,    0);
    run_op("rem",      4'd12, 16'd100,  16'd7,    0);
    run_op("div0",     4'd11, 16'd5,    16'd0,    0);
    run_op("rem0",     4'd12, 16'd5,    16'd0,    0);
    run_op("sra",      4'd8,  16'h8000, 16'h0013, 0);
    run_op("sll0",     4'd6,  16'hA5C3, 16'h0010, 0);
    run_op("slt",      4'd9,  16'h8000, 16'h0001, 0);
    run_op("op_f",     4'd15, 16'h1234, 16'h5678, 0);
    run_op("mul_poke", 4'd10, 16'hBEEF, 16'h0077, 1);

    for (int i = 0; i < 40; i++)
      run_op("rnd", 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), (i % 5) == 0);

    // Abort a DIV mid-iteration with reset.
    run_op("pre_rst", 4'd1, 16'h0003, 16'h0005, 0);
    @(negedge clk);
    start = 1; alu_op = 4'd11; alu_in1 = 16'd100; alu_in2 = 16'd7;
    @(posedge clk); #1; start = 0;
    repeat (8) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("rst_mid_div", {busy, done, alu_result, flag_z, flag_n, flag_c, flag_v, div0}, 0);
    @(negedge clk); rst = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk("no_done_after_rst", seen, 0);
    run_op("add_after_rst", 4'd0, 16'h1111, 16'h2222, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
